// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg
//   Shared types and sizing helpers for the seven-segment scan controller.
//   - state_t     : scan FSM states (idle / blanking gap / digit on)
//   - NIB_W       : width of one hex nibble
//   - cnt_width() : bits needed for a slot counter running 0..div-1
//   - idx_width() : bits needed for a digit index running 0..ndig-1
package seg_scan_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  function automatic int cnt_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

  function automatic int idx_width(input int ndig);
    return (ndig > 2) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if
//   Load/ready handshake carrying a new display value into the scan controller.
//   Ports (signals):
//     load    : producer requests transfer of val/dp_mask
//     ready   : consumer has no committed update pending
//     val     : hex nibbles, digit i = val[4i+3:4i], digit 0 rightmost
//     dp_mask : 1 = decimal point lit on digit i
//   Handshake: a transfer happens on a rising clk edge where load=1 and ready=1.
//   load while ready=0 is simply ignored (no queueing); the producer may drop
//   load at any time and val/dp_mask only need to be stable on the transfer edge.
//   Modports: master = producer, slave = seg_scan_ctrl.
interface seg_scan_ctrl_if #(
  parameter int NDIG = 4
);
  logic                load;
  logic                ready;
  logic [4*NDIG-1:0]   val;
  logic [NDIG-1:0]     dp_mask;

  modport master (output load, output val, output dp_mask, input ready);
  modport slave  (input load, input val, input dp_mask, output ready);
endinterface

// File: rtl/seg_scan_tick.sv
// seg_scan_tick
//   Slot counter for the scan controller. Counts 0..DIV-1 while run=1 and
//   wraps to 0; held at 0 while run=0 so every slot starts from a clean count.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     run         : 1 = counting (scan active), 0 = clear
//     blank_done  : strobe on the last blanking cycle of a slot (cnt==BLANK-1)
//     slot_end    : strobe on the last cycle of a slot (cnt==DIV-1)
module seg_scan_tick
  import seg_scan_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic blank_done,
  output logic slot_end
);

  localparam int CW = cnt_width(DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign blank_done = run && (cnt == CW'(BLANK - 1));
  assign slot_end   = run && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Time-multiplexed scan controller for NDIG common-anode 7-segment digits
//   sharing one external hex->segment decoder. A new value is latched through
//   the load/ready handshake into a shadow register and copied to the display
//   registers only at a frame boundary (or while idle), so a frame never shows
//   a mix of old and new digits.
//   Each digit slot is DIV cycles: BLANK cycles with all anodes off, then the
//   digit's anode is driven low for the rest of the slot.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     en         : 1 = scanning, 0 = display dark
//     bus        : seg_scan_ctrl_if.slave (load, ready, val, dp_mask)
//     nib        : nibble of the current digit for the shared decoder
//     dp_n       : decimal point, active-low
//     an_n       : anode enables, active-low, at most one low
//     dbg_state  : current FSM state, for observation only
//   Build option: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0
//   always lit; a lit decimal point keeps its digit and all lower ones lit).
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  seg_scan_ctrl_if.slave   bus,
  output logic [NIB_W-1:0] nib,
  output logic             dp_n,
  output logic [NDIG-1:0]  an_n,
  output state_t           dbg_state
);

  localparam int IW = idx_width(NDIG);
  localparam int VW = NIB_W * NDIG;

  state_t            state;
  state_t            state_nx;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_nx;
  logic              ready_q;
  logic [VW-1:0]     shadow_val;
  logic [NDIG-1:0]   shadow_dp;
  logic [VW-1:0]     disp_val;
  logic [NDIG-1:0]   disp_dp;
  logic [VW-1:0]     disp_val_nx;
  logic [NDIG-1:0]   disp_dp_nx;
  logic              accept;
  logic              commit;
  logic              run;
  logic              blank_done;
  logic              slot_end;
  logic [NDIG-1:0]   lit;
  logic [NDIG-1:0]   an_n_nx;
  logic [NIB_W-1:0]  nib_nx;
  logic              dp_n_nx;

  assign run = en && (state != S_IDLE);

  seg_scan_tick #(
    .DIV   (DIV),
    .BLANK (BLANK)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .blank_done (blank_done),
    .slot_end   (slot_end)
  );

  // Next-state logic. en=0 wins from any state and restarts at digit 0.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (!en) begin
      state_nx = S_IDLE;
      idx_nx   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_BLANK;
          idx_nx   = '0;
        end
        S_BLANK: begin
          if (blank_done) state_nx = S_ON;
        end
        S_ON: begin
          if (slot_end) begin
            state_nx = S_BLANK;
            idx_nx   = (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
          end
        end
        default: begin
          state_nx = S_IDLE;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // A pending update is committed while idle, or on the wrap from the last
  // digit back into the blanking gap of digit 0 (frame start). IDLE->BLANK is
  // already covered by the idle term.
  assign accept = bus.load && ready_q;
  assign commit = !ready_q &&
                  ((state == S_IDLE) ||
                   ((state == S_ON) && (state_nx == S_BLANK) && (idx_nx == '0)));

  assign disp_val_nx = commit ? shadow_val : disp_val;
  assign disp_dp_nx  = commit ? shadow_dp  : disp_dp;

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down: once a non-zero nibble or a
  // lit decimal point is seen, that digit and everything below it is lit.
  logic lz_any;
  always_comb begin
    lit    = '0;
    lz_any = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      lz_any = lz_any | (|disp_val_nx[NIB_W*i +: NIB_W]) | disp_dp_nx[i];
      lit[i] = lz_any || (i == 0);
    end
  end
`else
  assign lit = '1;
`endif

  // Outputs are computed from next-state values and registered, so they
  // change on the same edge as the state that causes them. nib/dp_n already
  // show the digit during its blanking gap so the decoder has settled.
  always_comb begin
    nib_nx  = '0;
    dp_n_nx = 1'b1;
    an_n_nx = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_nx == IW'(i)) begin
        nib_nx  = disp_val_nx[NIB_W*i +: NIB_W];
        dp_n_nx = ~disp_dp_nx[i];
        if ((state_nx == S_ON) && lit[i]) an_n_nx[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      ready_q    <= 1'b1;
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      an_n       <= '1;
      nib        <= '0;
      dp_n       <= 1'b1;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      disp_val <= disp_val_nx;
      disp_dp  <= disp_dp_nx;
      if (accept) begin
        shadow_val <= bus.val;
        shadow_dp  <= bus.dp_mask;
        ready_q    <= 1'b0;
      end else if (commit) begin
        ready_q <= 1'b1;
      end
      an_n <= an_n_nx;
      nib  <= nib_nx;
      dp_n <= dp_n_nx;
    end
  end

  assign bus.ready = ready_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with NDIG=4, DIV=8, BLANK=2.
//   Each slot is 8 clocks: 2 dark, then 6 with the digit's anode low.
module tb_seg_scan_ctrl;
  import seg_scan_pkg::*;

  localparam int T_NDIG  = 4;
  localparam int T_DIV   = 8;
  localparam int T_BLANK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] nib;
  logic       dp_n;
  logic [3:0] an_n;
  state_t     dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  seg_scan_ctrl_if #(.NDIG(T_NDIG)) bus ();

  seg_scan_ctrl #(
    .NDIG  (T_NDIG),
    .DIV   (T_DIV),
    .BLANK (T_BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bus       (bus),
    .nib       (nib),
    .dp_n      (dp_n),
    .an_n      (an_n),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // One digit slot: inputs driven just before the slot, expected outputs.
  typedef struct {
    logic        load;
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  nib;
    logic        dp_n;
    logic [3:0]  an_lo;
    logic        ready;
  } slot_vec_t;

  slot_vec_t tbl[12];
  slot_vec_t zero_tbl[4];
  slot_vec_t lz_tbl[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Drive the slot's inputs, then check all 8 cycles of the slot.
  task automatic run_slot(input slot_vec_t v);
    bus.load = v.load;
    if (v.load) begin
      bus.val     = v.val;
      bus.dp_mask = v.dp;
    end
    for (int c = 0; c < T_DIV; c++) begin
      @(negedge clk);
      chk("an_n",  16'(an_n), (c < T_BLANK) ? 16'hf : 16'(v.an_lo));
      chk("nib",   16'(nib), 16'(v.nib));
      chk("dp_n",  16'(dp_n), 16'(v.dp_n));
      chk("ready", 16'(bus.ready), 16'(v.ready));
      chk("state", 16'(dbg_state), (c < T_BLANK) ? 16'(S_BLANK) : 16'(S_ON));
      bus.load = 1'b0;
    end
  endtask

  // Stop scanning, load a value while idle, check the handshake, restart.
  task automatic idle_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] nib0);
    en = 1'b0;
    @(negedge clk);
    bus.load    = 1'b1;
    bus.val     = v;
    bus.dp_mask = dp;
    @(negedge clk);
    chk("idle_ready_low", 16'(bus.ready), 16'h0);
    bus.load = 1'b0;
    @(negedge clk);
    chk("idle_ready_high", 16'(bus.ready), 16'h1);
    chk("idle_nib", 16'(nib), 16'(nib0));
    chk("idle_an_n", 16'(an_n), 16'hf);
    en = 1'b1;
  endtask

  initial begin
    // Frame 1: 1234, dp on digit 2. Frame 2: same value, ABCD loaded before
    // digit 1, FFFF attempted before digit 2. Frame 3: ABCD, dp on digit 0.
    tbl[0]  = '{1'b0, 16'h0000, 4'b0000, 4'h4, 1'b1, 4'b1110, 1'b1};
    tbl[1]  = '{1'b0, 16'h0000, 4'b0000, 4'h3, 1'b1, 4'b1101, 1'b1};
    tbl[2]  = '{1'b0, 16'h0000, 4'b0000, 4'h2, 1'b0, 4'b1011, 1'b1};
    tbl[3]  = '{1'b0, 16'h0000, 4'b0000, 4'h1, 1'b1, 4'b0111, 1'b1};
    tbl[4]  = '{1'b0, 16'h0000, 4'b0000, 4'h4, 1'b1, 4'b1110, 1'b1};
    tbl[5]  = '{1'b1, 16'hABCD, 4'b0001, 4'h3, 1'b1, 4'b1101, 1'b0};
    tbl[6]  = '{1'b1, 16'hFFFF, 4'b1111, 4'h2, 1'b0, 4'b1011, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 4'b0000, 4'h1, 1'b1, 4'b0111, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 4'b0000, 4'hD, 1'b0, 4'b1110, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 4'b0000, 4'hC, 1'b1, 4'b1101, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 4'b0000, 4'hB, 1'b1, 4'b1011, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 4'b0000, 4'hA, 1'b1, 4'b0111, 1'b1};
    // After reset the display registers are zero.
`ifdef LEADING_ZERO_BLANK_EN
    zero_tbl[0] = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1110, 1'b1};
    zero_tbl[1] = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1111, 1'b1};
    zero_tbl[2] = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1111, 1'b1};
    zero_tbl[3] = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1111, 1'b1};
    lz_tbl[0]   = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1110, 1'b1};
    lz_tbl[1]   = '{1'b0, 16'h0000, 4'b0000, 4'h5, 1'b1, 4'b1101, 1'b1};
    lz_tbl[2]   = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1111, 1'b1};
    lz_tbl[3]   = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1111, 1'b1};
    lz_tbl[4]   = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1110, 1'b1};
    lz_tbl[5]   = '{1'b0, 16'h0000, 4'b0000, 4'h5, 1'b1, 4'b1101, 1'b1};
    lz_tbl[6]   = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1011, 1'b1};
    lz_tbl[7]   = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b0, 4'b0111, 1'b1};
`else
    zero_tbl[0] = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1110, 1'b1};
    zero_tbl[1] = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1101, 1'b1};
    zero_tbl[2] = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b1011, 1'b1};
    zero_tbl[3] = '{1'b0, 16'h0000, 4'b0000, 4'h0, 1'b1, 4'b0111, 1'b1};
    for (int i = 0; i < 8; i++) lz_tbl[i] = zero_tbl[i % 4];
`endif

    bus.load    = 1'b0;
    bus.val     = '0;
    bus.dp_mask = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_an_n",  16'(an_n), 16'hf);
    chk("rst_dp_n",  16'(dp_n), 16'h1);
    chk("rst_ready", 16'(bus.ready), 16'h1);
    chk("rst_nib",   16'(nib), 16'h0);
    chk("rst_state", 16'(dbg_state), 16'(S_IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_dark", 16'(an_n), 16'hf);

    idle_load(16'h1234, 4'b0100, 4'h4);
    for (int k = 0; k < 12; k++) run_slot(tbl[k]);

    // Drop en during ON of digit 2
    for (int k = 8; k < 10; k++) run_slot(tbl[k]);
    repeat (2) begin
      @(negedge clk);
      chk("d2_blank_an", 16'(an_n), 16'hf);
      chk("d2_blank_nib", 16'(nib), 16'hB);
    end
    repeat (3) begin
      @(negedge clk);
      chk("d2_on_an", 16'(an_n), 16'b1011);
    end
    en = 1'b0;
    @(negedge clk);
    chk("en_off_an", 16'(an_n), 16'hf);
    chk("en_off_state", 16'(dbg_state), 16'(S_IDLE));
    chk("en_off_nib", 16'(nib), 16'hD);
    chk("en_off_ready", 16'(bus.ready), 16'h1);
    @(negedge clk);
    chk("en_off_hold", 16'(an_n), 16'hf);
    en = 1'b1;
    for (int k = 8; k < 12; k++) run_slot(tbl[k]);

    // Reset mid-scan with an update pending
    bus.load    = 1'b1;
    bus.val     = 16'h1234;
    bus.dp_mask = 4'b0000;
    @(negedge clk);
    chk("pend_ready", 16'(bus.ready), 16'h0);
    chk("pend_an", 16'(an_n), 16'hf);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_an", 16'(an_n), 16'b1110);
    chk("pre_rst_nib", 16'(nib), 16'hD);
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk("async_an",    16'(an_n), 16'hf);
    chk("async_dp_n",  16'(dp_n), 16'h1);
    chk("async_ready", 16'(bus.ready), 16'h1);
    chk("async_nib",   16'(nib), 16'h0);
    chk("async_state", 16'(dbg_state), 16'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_an", 16'(an_n), 16'hf);
      chk("post_rst_ready", 16'(bus.ready), 16'h1);
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) run_slot(zero_tbl[k]);

`ifdef LEADING_ZERO_BLANK_EN
    idle_load(16'h0050, 4'b0000, 4'h0);
    for (int k = 0; k < 4; k++) run_slot(lz_tbl[k]);
    idle_load(16'h0050, 4'b1000, 4'h0);
    for (int k = 4; k < 8; k++) run_slot(lz_tbl[k]);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
